// File: rtl/pfifo_pkg.sv
// -----------------------------------------------------------------------------
// pfifo_pkg
// Shared definitions for the packet FIFO datapath (writer now, reader later).
//   pfifo_state_t : FSM state encoding (IDLE, RECV, BAD, PUT, CLOSE)
//   len_width()   : width of a per-packet length counter that must be able to
//                   hold MAX_LEN+1 (the saturated "too long" value).
// -----------------------------------------------------------------------------
package pfifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,  // no packet open
        ST_RECV  = 3'd1,  // packet open, good so far
        ST_BAD   = 3'd2,  // packet open, will be dropped
        ST_PUT   = 3'd3,  // one-cycle strobe slot after every accepted word
        ST_CLOSE = 3'd4   // commit/drop decision and strobe
    } pfifo_state_t;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1) + 1;
    endfunction

endpackage

// File: rtl/pfifo_writer_len_counter.sv
// -----------------------------------------------------------------------------
// pkt_len_counter
// Saturating per-packet word counter. Counts up to MAX_LEN+1 and stays there,
// so an arbitrarily long packet can never wrap back into the legal range.
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   clear         : synchronous clear (takes priority over inc)
//   inc           : count one accepted word
//   len           : current count
//   over_max      : len > MAX_LEN (saturated)
//   under_min     : len < MIN_LEN
// -----------------------------------------------------------------------------
module pkt_len_counter
    import pfifo_pkg::*;
#(
    parameter int MIN_LEN = 1,
    parameter int MAX_LEN = 15,
    parameter int LEN_W   = len_width(MAX_LEN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [LEN_W-1:0] len,
    output logic             over_max,
    output logic             under_min
);

    localparam logic [LEN_W-1:0] SAT_V = LEN_W'(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MIN_V = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] ONE_V = LEN_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len <= '0;
        end else if (clear) begin
            len <= '0;
        end else if (inc && (len != SAT_V)) begin
            len <= len + ONE_V;
        end
    end

    assign over_max  = (len == SAT_V);
    assign under_min = (len < MIN_V);

endmodule

// File: rtl/pfifo_writer.sv
// -----------------------------------------------------------------------------
// pfifo_writer
// Packet ingress stage in front of pfifo. Every accepted word is re-timed into
// an isolated one-cycle `put`, and every packet ends with exactly one `commit`
// or `drop`. Packets that are too long, too short, flagged with `error`, or
// that hit a full FIFO are dropped, so the FIFO only keeps whole good packets.
//
// Handshake: a word transfers in every cycle where valid & ready are both 1.
// ready is a function of the FSM state only (forced low while reset is
// asserted); the upstream must hold in/last/error stable while valid is high
// and ready is low.
//
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   in, valid, last, error: upstream word stream (error sampled with last)
//   ready                 : upstream may transfer this cycle
//   out, put              : word and write strobe to FIFO
//   commit, drop          : packet close strobes to FIFO
//   full                  : FIFO full, sampled only in the accept cycle
//   commit_count,
//   drop_count            : wrapping strobe counters, present only when
//                           PFIFO_WRITER_STATS_EN is defined
// -----------------------------------------------------------------------------
module pfifo_writer
    import pfifo_pkg::*;
#(
    parameter int W       = 8,
    parameter int MIN_LEN = 1,
    parameter int MAX_LEN = 15
`ifdef PFIFO_WRITER_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [W-1:0]     in,
    input  logic             valid,
    input  logic             last,
    input  logic             error,
    output logic             ready,
    output logic [W-1:0]     out,
    output logic             put,
    output logic             commit,
    output logic             drop,
    input  logic             full
`ifdef PFIFO_WRITER_STATS_EN
    ,
    output logic [CNT_W-1:0] commit_count,
    output logic [CNT_W-1:0] drop_count
`endif
);

    localparam int               LEN_W = len_width(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_V = LEN_W'(MAX_LEN);

    pfifo_state_t     state, state_d;
    logic [W-1:0]     out_d;
    logic             put_d, commit_d, drop_d;
    // Packet context carried from the accept cycle into PUT/CLOSE.
    logic             pkt_bad, pkt_bad_d;
    logic             closing, closing_d;
    logic             pkt_err, pkt_err_d;

    logic             len_clr, len_inc;
    logic [LEN_W-1:0] len;
    logic             over_max, under_min;
    logic             accept;
    logic             word_ok;

    pkt_len_counter #(
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_len (
        .clock     (clock),
        .reset     (reset),
        .clear     (len_clr),
        .inc       (len_inc),
        .len       (len),
        .over_max  (over_max),
        .under_min (under_min)
    );

    assign ready  = !reset && ((state == ST_IDLE) || (state == ST_RECV) || (state == ST_BAD));
    assign accept = valid && ready;

    // The incremented length stays legal only if the current one is below MAX.
    assign word_ok = (state != ST_BAD) && !full && !over_max && (len < MAX_V);

    always_comb begin
        state_d   = state;
        out_d     = out;
        put_d     = 1'b0;
        commit_d  = 1'b0;
        drop_d    = 1'b0;
        pkt_bad_d = pkt_bad;
        closing_d = closing;
        pkt_err_d = pkt_err;
        len_clr   = 1'b0;
        len_inc   = 1'b0;

        case (state)
            ST_IDLE, ST_RECV, ST_BAD: begin
                if (accept) begin
                    len_inc   = 1'b1;
                    // Recomputed from scratch so a new packet never inherits
                    // the previous packet's badness.
                    pkt_bad_d = !word_ok;
                    if (word_ok) begin
                        out_d = in;
                        put_d = 1'b1;
                    end
                    closing_d = last;
                    pkt_err_d = last && error;
                    state_d   = ST_PUT;
                end
            end

            ST_PUT: begin
                if (closing) begin
                    state_d = ST_CLOSE;
                end else if (pkt_bad) begin
                    state_d = ST_BAD;
                end else begin
                    state_d = ST_RECV;
                end
            end

            ST_CLOSE: begin
                // First CLOSE cycle decides and registers the strobe; the
                // second one (strobe visible) returns to IDLE.
                if (commit || drop) begin
                    state_d   = ST_IDLE;
                    len_clr   = 1'b1;
                    pkt_bad_d = 1'b0;
                    closing_d = 1'b0;
                    pkt_err_d = 1'b0;
                end else if (!pkt_bad && !pkt_err && !under_min && !over_max) begin
                    commit_d = 1'b1;
                end else begin
                    drop_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                len_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            out     <= '0;
            put     <= 1'b0;
            commit  <= 1'b0;
            drop    <= 1'b0;
            pkt_bad <= 1'b0;
            closing <= 1'b0;
            pkt_err <= 1'b0;
        end else begin
            state   <= state_d;
            out     <= out_d;
            put     <= put_d;
            commit  <= commit_d;
            drop    <= drop_d;
            pkt_bad <= pkt_bad_d;
            closing <= closing_d;
            pkt_err <= pkt_err_d;
        end
    end

`ifdef PFIFO_WRITER_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_count <= '0;
            drop_count   <= '0;
        end else begin
            if (commit) commit_count <= commit_count + CNT_ONE;
            if (drop)   drop_count   <= drop_count + CNT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_pfifo_writer.sv
// -----------------------------------------------------------------------------
// tb_pfifo_writer
// Directed bench for pfifo_writer (W=8, MIN_LEN=1, MAX_LEN=15). Expected put
// data and close kinds come from a small packet model inside the send task and
// are checked by a negedge monitor. Stats checks exist when
// PFIFO_WRITER_STATS_EN is defined (CNT_W=2).
// -----------------------------------------------------------------------------
module tb_pfifo_writer;

    localparam int W       = 8;
    localparam int MIN_LEN = 1;
    localparam int MAX_LEN = 15;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_d  = '0;
    logic         valid = 1'b0;
    logic         last  = 1'b0;
    logic         error = 1'b0;
    logic         full  = 1'b0;
    logic         ready;
    logic [W-1:0] out;
    logic         put, commit, drop;
`ifdef PFIFO_WRITER_STATS_EN
    logic [1:0]   commit_count, drop_count;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_close_q[$];
    int           m_len = 0;
    bit           m_bad = 1'b0;

    int  puts_seen = 0, commits_seen = 0, drops_seen = 0;
    bit  prev_put = 1'b0;
    int  p0, c0, d0;

    pfifo_writer #(
        .W       (W),
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN)
`ifdef PFIFO_WRITER_STATS_EN
        ,
        .CNT_W   (2)
`endif
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .in     (in_d),
        .valid  (valid),
        .last   (last),
        .error  (error),
        .ready  (ready),
        .out    (out),
        .put    (put),
        .commit (commit),
        .drop   (drop),
        .full   (full)
`ifdef PFIFO_WRITER_STATS_EN
        ,
        .commit_count (commit_count),
        .drop_count   (drop_count)
`endif
    );

    // clock / reset block
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: called at a negedge, returns at the negedge after the accept edge
    task automatic send(input logic [W-1:0] d, input bit l, input bit e, input bit f);
        int guard = 0;
        while (!ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (!ready) begin
            chk("ready_timeout", 32'(ready), 32'd1);
            return;
        end
        valid = 1'b1; in_d = d; last = l; error = e; full = f;
        // packet model
        if (m_len <= MAX_LEN) m_len++;
        if (!m_bad && !f && m_len <= MAX_LEN) exp_q.push_back(d);
        else m_bad = 1'b1;
        if (l) begin
            exp_close_q.push_back(!m_bad && !e && (m_len >= MIN_LEN));
            m_len = 0;
            m_bad = 1'b0;
        end
        @(posedge clock);
        #1;
        valid = 1'b0; last = 1'b0; error = 1'b0; full = 1'b0;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic snap();
        p0 = puts_seen; c0 = commits_seen; d0 = drops_seen;
    endtask

    // scoreboard / monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (put || commit || drop)
                chk("strobe_exclusive", 32'(put) + 32'(commit) + 32'(drop), 32'd1);
            if (put) begin
                puts_seen++;
                chk("put_isolated", 32'(prev_put), 32'd0);
                if (exp_q.size() == 0) chk("put_unexpected", 32'd1, 32'd0);
                else chk("put_data", 32'(out), 32'(exp_q.pop_front()));
            end
            if (commit) commits_seen++;
            if (drop)   drops_seen++;
            if (commit || drop) begin
                if (exp_close_q.size() == 0) chk("close_unexpected", 32'd1, 32'd0);
                else chk("close_kind_commit", 32'(commit), 32'(exp_close_q.pop_front()));
            end
            prev_put = put;
        end else begin
            prev_put = 1'b0;
        end
    end

    initial begin
        // reset state
        @(negedge clock);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_put", 32'(put), 32'd0);
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("ready_after_release", 32'(ready), 32'd1);
        @(negedge clock);

        // 3-word packet with exact timing
        snap();
        send(8'h11, 0, 0, 0);
        chk("t1_put_n1", 32'(put), 32'd1);
        chk("t1_out_n1", 32'(out), 32'h11);
        chk("t1_ready_n1", 32'(ready), 32'd0);
        @(negedge clock);
        chk("t1_put_n2", 32'(put), 32'd0);
        chk("t1_ready_n2", 32'(ready), 32'd1);
        chk("t1_out_held", 32'(out), 32'h11);
        send(8'h22, 0, 0, 0);
        send(8'h33, 1, 0, 0);
        chk("t1_last_put_n1", 32'(put), 32'd1);
        chk("t1_last_ready_n1", 32'(ready), 32'd0);
        @(negedge clock);
        chk("t1_ready_n2b", 32'(ready), 32'd0);
        chk("t1_commit_n2", 32'(commit), 32'd0);
        @(negedge clock);
        chk("t1_commit_n3", 32'(commit), 32'd1);
        chk("t1_drop_n3", 32'(drop), 32'd0);
        chk("t1_ready_n3", 32'(ready), 32'd0);
        @(negedge clock);
        chk("t1_ready_n4", 32'(ready), 32'd1);
        chk("t1_commit_n4", 32'(commit), 32'd0);
        chk("t1_puts", 32'(puts_seen - p0), 32'd3);

        // 16-word packet: word 16 exceeds MAX_LEN
        snap();
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i), (i == 15), 0, 0);
        idle(4);
        chk("t2_puts", 32'(puts_seen - p0), 32'd15);
        chk("t2_drops", 32'(drops_seen - d0), 32'd1);
        chk("t2_commits", 32'(commits_seen - c0), 32'd0);

        // 15-word packet: exactly MAX_LEN is still good
        snap();
        for (int i = 0; i < 15; i++) send(8'($urandom_range(0, 255)), (i == 14), 0, 0);
        idle(4);
        chk("t2b_puts", 32'(puts_seen - p0), 32'd15);
        chk("t2b_commits", 32'(commits_seen - c0), 32'd1);

        // 2-word packet with error on last
        snap();
        send(8'h5C, 0, 0, 0);
        send(8'h5D, 1, 1, 0);
        idle(4);
        chk("t3_puts", 32'(puts_seen - p0), 32'd2);
        chk("t3_drops", 32'(drops_seen - d0), 32'd1);
        chk("t3_commits", 32'(commits_seen - c0), 32'd0);

        // full on 2nd of 4 words, then a good 1-word packet
        snap();
        send(8'h01, 0, 0, 0);
        send(8'h02, 0, 0, 1);
        chk("t4_no_put_full", 32'(put), 32'd0);
        send(8'h03, 0, 0, 0);
        send(8'h04, 1, 0, 0);
        idle(4);
        chk("t4_puts", 32'(puts_seen - p0), 32'd1);
        chk("t4_drops", 32'(drops_seen - d0), 32'd1);
        send(8'hAA, 1, 0, 0);
        idle(4);
        chk("t4_commits", 32'(commits_seen - c0), 32'd1);
        chk("t4_puts_total", 32'(puts_seen - p0), 32'd2);

        // reset one cycle after the 2nd word of a 5-word packet
        snap();
        send(8'h61, 0, 0, 0);
        send(8'h62, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_put", 32'(put), 32'd0);
        chk("t5_rst_out", 32'(out), 32'd0);
        chk("t5_rst_drop", 32'(drop), 32'd0);
        chk("t5_rst_ready", 32'(ready), 32'd0);
        m_len = 0;
        m_bad = 1'b0;
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_ready_release", 32'(ready), 32'd1);
        @(negedge clock);
        chk("t5_ready_next", 32'(ready), 32'd1);
        idle(3);
        chk("t5_no_drop", 32'(drops_seen - d0), 32'd0);
        send(8'h5A, 1, 0, 0);
        idle(4);
        chk("t5_commit_after", 32'(commits_seen - c0), 32'd1);
        chk("t5_drops_after", 32'(drops_seen - d0), 32'd0);

`ifdef PFIFO_WRITER_STATS_EN
        // stats wrap with CNT_W=2
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("st_commit_rst", 32'(commit_count), 32'd0);
        chk("st_drop_rst", 32'(drop_count), 32'd0);
        @(negedge clock);
        for (int i = 0; i < 5; i++) send(8'(8'h70 + i), 1, 0, 0);
        send(8'h7F, 1, 1, 0);
        idle(4);
        chk("st_commit_wrap", 32'(commit_count), 32'd1);
        chk("st_drop_count", 32'(drop_count), 32'd1);
`endif

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("close_q_drained", 32'(exp_close_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pfifo_writer.md
# pfifo_writer

Synchronous packet ingress stage that sits directly upstream of the packet FIFO (`pfifo`). It accepts a word stream with valid/ready, last and error flags. It re-times each accepted word into an isolated `put` strobe, and closes every packet with exactly one `commit` or `drop` strobe. Length policing and FIFO-overflow handling live here, so the FIFO only ever holds whole, good packets.

## Interface
- `W`, 8: data word width.
- `MIN_LEN`, 1: minimum good packet length in words (≥ 1).
- `MAX_LEN`, 15: maximum good packet length in words; must be < FIFO depth.
- `CNT_W`, 16: statistics counter width (only with `PFIFO_WRITER_STATS_EN`).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in`  in  W  upstream data word.
- `valid`  in  1  upstream word present.
- `last`  in  1  word is the final word of its packet.
- `error`  in  1  upstream marks packet bad; sampled with `last`.
- `ready`  out  1  word accepted this cycle when `valid & ready`.
- `out`  out  W  word to FIFO `in`.
- `put`  out  1  FIFO write strobe.
- `commit`  out  1  FIFO packet commit strobe.
- `drop`  out  1  FIFO packet discard strobe.
- `full`  in  1  FIFO `full`.
- `commit_count`, `drop_count`  out  CNT_W  statistics (macro only).

## Operation
- FSM states:
  - IDLE: no packet open.
  - RECV: packet open, good so far.
  - BAD: packet open, will be dropped.
  - PUT: strobe cycle.
  - CLOSE: commit/drop strobe cycle.
- Per-packet length counter `len`, width clog2(MAX_LEN+1)+1, saturating at MAX_LEN+1. Cleared on entry to IDLE.
- Handling of an accepted word:
  - `len` increments.
  - If the packet is good, `full`=0 and the new `len` ≤ MAX_LEN: register the word into `out` and strobe `put`.
  - Otherwise the word is discarded (no `put`) and the packet goes BAD.
- First word of a packet moves IDLE→RECV (or BAD).
- On an accepted `last` word the packet closes. It is committed only if it is still good, `error`=0 and `len` ≥ MIN_LEN; otherwise it is dropped.
- Once BAD, the packet stays BAD until its `last` word; every word is still accepted and discarded.
- Exactly one of `commit` or `drop` per packet; never both; never without a preceding first word.
- `put`, `commit` and `drop` are mutually exclusive in every cycle.

## Timing
- Reset values: `ready`=0 during reset and 1 in the first cycle after release; `out`=0, `put`=0, `commit`=0, `drop`=0, counters 0, state IDLE.
- Accept at cycle N: `out` valid from N+1, `put`=1 in N+1 only, `ready`=0 in N+1, `ready`=1 in N+2.
- Peak throughput is one word per 2 cycles. `put` always returns low between words, so the FIFO sees one rising edge per word. `out` is held stable until the next accepted word.
- Discarded words follow the same timing with `put` held 0.
- `last` accepted at N: `commit` or `drop`=1 in N+3 only; `ready`=0 in N+1..N+3, 1 in N+4.
- Strobes are registered outputs; no combinational path from inputs to `put`/`commit`/`drop`.
- `ready` depends only on state.
- `full` is sampled in the accept cycle N only.
- `reset` mid-packet: the FSM returns to IDLE immediately and no `drop` is issued. The FIFO shares `reset` and discards the partial packet itself.

## Configuration
- `PFIFO_WRITER_STATS_EN` defined:
  - `commit_count` and `drop_count` ports exist.
  - Each increments by 1 in the cycle its strobe is high, wrapping modulo 2^CNT_W.
  - Both clear on `reset`.
- Macro undefined: both ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package `pfifo_pkg`: FSM state encoding constants (IDLE, RECV, BAD, PUT, CLOSE) and the clog2-based length-width helper, reused by the future downstream reader.
- One sub-module, `pkt_len_counter`: saturating length counter with clear and increment inputs, plus `over_max` and `under_min` flag outputs.

## Test plan
- Reset release, then a 3-word packet 0x11, 0x22, 0x33 with `last` on 0x33: three isolated `put` pulses carrying those values 2 cycles apart, then `commit` exactly 3 cycles after the `last` accept, no `drop`.
- Packet of 16 words with MAX_LEN=15: 15 `put` pulses, word 16 discarded, `drop` at close, `commit` never.
- 2-word packet with `error`=1 on `last`: 2 `put` pulses, then `drop`.
- `full`=1 forced during the 2nd of 4 words: word 2 gets no `put`, words 3–4 are accepted but discarded, `drop` at close; the next packet 0xAA (`last`) with `full`=0 is committed.
- `reset` pulsed one cycle after the 2nd word of a 5-word packet: all outputs 0, no `drop`, `ready`=1 the cycle after release, and a following 1-word packet commits normally.
- With `PFIFO_WRITER_STATS_EN` and CNT_W=2: 5 good packets and 1 bad packet give `commit_count`=1 (wrap) and `drop_count`=1.
